// File: rtl/regfile_pkg.sv
// Shared register-file constants used by the register file, decode and hazard units.
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int REG_ZERO   = 0;

  // Number of architectural registers for a given address width.
  function automatic int num_regs(input int addr_w);
    return 32'sd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reservations set, writebacks clear, set wins.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_addr,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic              resv_conflict
);

  localparam int NUM_REGS = num_regs(ADDR_W);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                resv_eff_s;

  // Reservations of the hardwired zero register are ignored entirely.
  always_comb begin
    resv_eff_s = resv_en;
    if ((ZERO_REG != 0) && (resv_addr == ADDR_W'(REG_ZERO))) begin
      resv_eff_s = 1'b0;
    end else begin
      resv_eff_s = resv_en;
    end
  end

  // Next busy vector: a new reservation overrides a retiring writeback.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((ZERO_REG != 0) && (i == REG_ZERO)) begin
        busy_d[i] = 1'b0;
      end else if (resv_eff_s && (resv_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if ((wr_en_a && (wr_addr_a == ADDR_W'(i))) ||
                   (wr_en_b && (wr_addr_b == ADDR_W'(i)))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // Busy state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Busy lookups are masked by a same-cycle write, whose data is bypassed.
  always_comb begin
    rd_busy1 = busy_q[rd_addr1] &
               ~((wr_en_a && (wr_addr_a == rd_addr1)) || (wr_en_b && (wr_addr_b == rd_addr1)));
    rd_busy2 = busy_q[rd_addr2] &
               ~((wr_en_a && (wr_addr_a == rd_addr2)) || (wr_en_b && (wr_addr_b == rd_addr2)));
    resv_conflict = resv_eff_s & busy_q[resv_addr];
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with write-to-read bypass and busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_addr,
  output logic              resv_conflict
);

  localparam int NUM_REGS = num_regs(ADDR_W);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  // Next storage contents: port B overrides port A on an address collision.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
      if ((ZERO_REG != 0) && (i == REG_ZERO)) begin
        mem_d[i] = '0;
      end else if (wr_en_b && (wr_addr_b == ADDR_W'(i))) begin
        mem_d[i] = wr_data_b;
      end else if (wr_en_a && (wr_addr_a == ADDR_W'(i))) begin
        mem_d[i] = wr_data_a;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Storage register with synchronous reset to all zeros.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read port 1: zero register, then port B bypass, port A bypass, storage.
  always_comb begin
    rd_data1 = mem_q[rd_addr1];
    if ((ZERO_REG != 0) && (rd_addr1 == ADDR_W'(REG_ZERO))) begin
      rd_data1 = '0;
    end else if (wr_en_b && (wr_addr_b == rd_addr1)) begin
      rd_data1 = wr_data_b;
    end else if (wr_en_a && (wr_addr_a == rd_addr1)) begin
      rd_data1 = wr_data_a;
    end else begin
      rd_data1 = mem_q[rd_addr1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd_data2 = mem_q[rd_addr2];
    if ((ZERO_REG != 0) && (rd_addr2 == ADDR_W'(REG_ZERO))) begin
      rd_data2 = '0;
    end else if (wr_en_b && (wr_addr_b == rd_addr2)) begin
      rd_data2 = wr_data_b;
    end else if (wr_en_a && (wr_addr_a == rd_addr2)) begin
      rd_data2 = wr_data_a;
    end else begin
      rd_data2 = mem_q[rd_addr2];
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .wr_en_a       (wr_en_a),
    .wr_addr_a     (wr_addr_a),
    .wr_en_b       (wr_en_b),
    .wr_addr_b     (wr_addr_b),
    .resv_en       (resv_en),
    .resv_addr     (resv_addr),
    .rd_busy1      (rd_busy1),
    .rd_busy2      (rd_busy2),
    .resv_conflict (resv_conflict)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (ZERO_REG=1 and ZERO_REG=0 instances).
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_addr1, rd_addr2;
  logic        wr_en_a, wr_en_b, resv_en;
  logic [3:0]  wr_addr_a, wr_addr_b, resv_addr;
  logic [15:0] wr_data_a, wr_data_b;

  logic [15:0] z_data1, z_data2, o_data1, o_data2;
  logic        z_busy1, z_busy2, z_conf, o_busy1, o_busy2, o_conf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(z_data1), .rd_data2(z_data2),
    .rd_busy1(z_busy1), .rd_busy2(z_busy2),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .resv_en(resv_en), .resv_addr(resv_addr), .resv_conflict(z_conf)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(o_data1), .rd_data2(o_data2),
    .rd_busy1(o_busy1), .rd_busy2(o_busy2),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .resv_en(resv_en), .resv_addr(resv_addr), .resv_conflict(o_conf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0; resv_en = 1'b0;
    wr_addr_a = 4'd0; wr_addr_b = 4'd0; resv_addr = 4'd0;
    wr_data_a = 16'h0000; wr_data_b = 16'h0000;
  endtask

  // Advance one rising edge and move away from it before driving inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    rst = 1'b1;
    tick();
    idle();
    #1;
    // Reset state
    rd_addr1 = 4'd3; rd_addr2 = 4'd6;
    #1;
    check("rst_data1", z_data1, 32'h0);
    check("rst_busy1", z_busy1, 32'h0);
    check("rst_conf", z_conf, 32'h0);

    // 1: write r3, then reset with a write/reservation present
    wr_en_a = 1'b1; wr_addr_a = 4'd3; wr_data_a = 16'h1234;
    tick();
    idle();
    #1;
    check("t1_stored_r3", z_data1, 32'h1234);
    rst = 1'b1;
    wr_en_b = 1'b1; wr_addr_b = 4'd6; wr_data_b = 16'h5555;
    resv_en = 1'b1; resv_addr = 4'd6;
    tick();
    idle();
    #1;
    check("t1_r3_after_rst", z_data1, 32'h0);
    check("t1_r6_write_dropped", z_data2, 32'h0);
    for (int i = 0; i < 16; i++) begin
      rd_addr1 = 4'(i);
      #1;
      check($sformatf("t1_busy_r%0d", i), z_busy1, 32'h0);
    end

    // 2: port A write bypasses to read port 1, then persists
    wr_en_a = 1'b1; wr_addr_a = 4'd5; wr_data_a = 16'hBEEF; rd_addr1 = 4'd5;
    #1;
    check("t2_bypass", z_data1, 32'hBEEF);
    tick();
    idle();
    #1;
    check("t2_stored", z_data1, 32'hBEEF);

    // 3: both ports to r7, port B wins
    wr_en_a = 1'b1; wr_addr_a = 4'd7; wr_data_a = 16'h1111;
    wr_en_b = 1'b1; wr_addr_b = 4'd7; wr_data_b = 16'h2222;
    rd_addr2 = 4'd7;
    #1;
    check("t3_bypass_b_wins", z_data2, 32'h2222);
    tick();
    idle();
    #1;
    check("t3_stored_b_wins", z_data2, 32'h2222);

    // 4: zero register (dut) vs ordinary r0 (dut0)
    rd_addr1 = 4'd0;
    wr_en_a = 1'b1; wr_addr_a = 4'd0; wr_data_a = 16'hFFFF;
    resv_en = 1'b1; resv_addr = 4'd0;
    #1;
    check("t4_z_bypass", z_data1, 32'h0);
    check("t4_z_conf", z_conf, 32'h0);
    check("t4_o_bypass", o_data1, 32'hFFFF);
    tick();
    idle();
    resv_en = 1'b1; resv_addr = 4'd0;
    #1;
    check("t4_z_data", z_data1, 32'h0);
    check("t4_z_busy", z_busy1, 32'h0);
    check("t4_z_conf2", z_conf, 32'h0);
    check("t4_o_data", o_data1, 32'hFFFF);
    check("t4_o_busy_set_wins", o_busy1, 32'h1);
    check("t4_o_conf", o_conf, 32'h1);
    tick();
    idle();
    wr_en_a = 1'b1; wr_addr_a = 4'd0; wr_data_a = 16'hFFFF;
    #1;
    check("t4_o_busy_masked", o_busy1, 32'h0);
    tick();
    idle();
    #1;
    check("t4_o_busy_clear", o_busy1, 32'h0);

    // 5: scoreboard on r4
    rd_addr1 = 4'd4;
    resv_en = 1'b1; resv_addr = 4'd4;
    #1;
    check("t5_busy_n", z_busy1, 32'h0);
    tick();
    idle();
    #1;
    check("t5_busy_n1", z_busy1, 32'h1);
    tick();
    #1;
    check("t5_busy_n2", z_busy1, 32'h1);
    tick();
    wr_en_a = 1'b1; wr_addr_a = 4'd4; wr_data_a = 16'h4444;
    #1;
    check("t5_busy_n3_masked", z_busy1, 32'h0);
    check("t5_data_n3", z_data1, 32'h4444);
    tick();
    idle();
    #1;
    check("t5_busy_n4", z_busy1, 32'h0);
    resv_en = 1'b1; resv_addr = 4'd4;
    wr_en_b = 1'b1; wr_addr_b = 4'd4; wr_data_b = 16'h4545;
    tick();
    idle();
    #1;
    check("t5_set_wins", z_busy1, 32'h1);
    check("t5_data_stored", z_data1, 32'h4545);

    // 6: WAW reservation on r9
    rd_addr2 = 4'd9;
    resv_en = 1'b1; resv_addr = 4'd9;
    #1;
    check("t6_conf_first", z_conf, 32'h0);
    tick();
    resv_en = 1'b1; resv_addr = 4'd9;
    #1;
    check("t6_conf_second", z_conf, 32'h1);
    check("t6_busy", z_busy2, 32'h1);
    tick();
    idle();
    #1;
    check("t6_conf_idle", z_conf, 32'h0);
    check("t6_busy_held", z_busy2, 32'h1);
    wr_en_b = 1'b1; wr_addr_b = 4'd9; wr_data_b = 16'h9999;
    tick();
    idle();
    #1;
    check("t6_busy_cleared", z_busy2, 32'h0);
    check("t6_data", z_data2, 32'h9999);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
